// File: rtl/stencil_harness_pkg.sv
// Shared types for the stencil stream harness: run-state encoding, the
// widest lane word used for arithmetic, and the output-signature step.
package stencil_harness_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Lane words are carried at this width and cut down to DATA_W where used.
    localparam int unsigned LANE_W_MAX = 64;
    typedef logic [LANE_W_MAX-1:0] lane_word_t;

    // Signature step within a w-bit field: rotate left by one, fold in the word.
    function automatic lane_word_t chk_step(input lane_word_t old_v,
                                            input lane_word_t word_x,
                                            input int unsigned w);
        lane_word_t mask;
        lane_word_t v;
        lane_word_t rot;
        mask = (w >= LANE_W_MAX) ? '1 : ((lane_word_t'(1) << w) - lane_word_t'(1));
        v    = old_v & mask;
        rot  = ((v << 1) | (v >> (w - 1))) & mask;
        return rot ^ (word_x & mask);
    endfunction

endpackage

// File: rtl/stencil_stream_harness_ramp.sv
// stencil_ramp_source: registered multi-lane ramp feeding the accelerator's
// input stream. Holds the lane words, the modular step and the count of
// consumed words; freezes on the last word and flags reads past the end.
module stencil_ramp_source
    import stencil_harness_pkg::*;
#(
    parameter int unsigned LANES     = 1,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned IN_TOKENS = 4096,
    parameter int unsigned START_VAL = 0,
    parameter int unsigned STRIDE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [DATA_W-1:0] data_o [0:LANES-1],
    output logic              ovr_o
);

    // Distance between the same lane of consecutive words, wrapped to DATA_W.
    localparam logic [DATA_W-1:0] STEP = DATA_W'(64'(LANES) * 64'(STRIDE));

    logic [DATA_W-1:0] lane_q [0:LANES-1];
    logic [31:0]       count_q;
    logic              take;
    logic              step_en;

    function automatic logic [DATA_W-1:0] lane_init(input int unsigned l);
        return DATA_W'(64'(START_VAL) + 64'(l) * 64'(STRIDE));
    endfunction

    // A read is accepted while words remain; the last accepted word stays on the bus.
    assign take    = adv_i && (count_q < IN_TOKENS);
    assign step_en = take && (count_q < (IN_TOKENS - 1));
    assign ovr_o   = adv_i && !(count_q < IN_TOKENS);
    assign data_o  = lane_q;

    // Lane registers and consumed-word count; load rewinds to the starting ramp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned l = 0; l < LANES; l++) lane_q[l] <= lane_init(l);
            count_q <= '0;
        end else if (load_i) begin
            for (int unsigned l = 0; l < LANES; l++) lane_q[l] <= lane_init(l);
            count_q <= '0;
        end else if (take) begin
            count_q <= count_q + 32'd1;
            if (step_en) begin
                for (int unsigned l = 0; l < LANES; l++) lane_q[l] <= lane_q[l] + STEP;
            end
        end
    end

endmodule

// File: rtl/stencil_stream_harness.sv
// stencil_stream_harness: sequences flush, drives a ramp into a stencil
// accelerator's input stream and checks its output stream (count, signature,
// idle timeout, overrun/underrun) with an on-chip pass flag.
// Optional HARNESS_CHECKSUM_EN: when defined the running output signature is
// built; otherwise checksum reads 0.
module stencil_stream_harness
    import stencil_harness_pkg::*;
#(
    parameter int unsigned LANES        = 1,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned IN_TOKENS    = 4096,
    parameter int unsigned OUT_TOKENS   = 4096,
    parameter int unsigned START_VAL    = 0,
    parameter int unsigned STRIDE       = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              flush,
    input  logic              in_read_en,
    output logic [DATA_W-1:0] in_data [0:LANES-1],
    input  logic              out_write_valid,
    input  logic [DATA_W-1:0] out_data [0:LANES-1],
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              overrun,
    output logic              underrun,
    output logic [31:0]       out_count,
    output logic [DATA_W-1:0] checksum
);

    state_e      state_q;
    logic [31:0] fcnt_q;
    logic        flush_q, busy_q, done_q, pass_q;
    logic [31:0] out_count_q, out_count_d;
    logic [31:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic        underrun_q, underrun_d;
    logic        in_run, begin_run, run_end, src_ovr;
    logic [DATA_W-1:0] lane_xor;

    assign in_run    = (state_q == S_RUN);
    assign begin_run = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    stencil_ramp_source #(
        .LANES(LANES), .DATA_W(DATA_W), .IN_TOKENS(IN_TOKENS),
        .START_VAL(START_VAL), .STRIDE(STRIDE)
    ) u_src (
        .clk    (clk),
        .rst    (rst),
        .load_i (begin_run),
        .adv_i  (in_run && in_read_en),
        .data_o (in_data),
        .ovr_o  (src_ovr)
    );

    // Next values of the sink counters and sticky flags for this cycle.
    always_comb begin
        out_count_d = out_count_q;
        idle_d      = idle_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        if (begin_run) begin
            out_count_d = '0;
            idle_d      = '0;
            timeout_d   = 1'b0;
            overrun_d   = 1'b0;
            underrun_d  = 1'b0;
        end else if (in_run) begin
            if (src_ovr) overrun_d = 1'b1;
            if (out_write_valid) begin
                if (out_count_q >= OUT_TOKENS) underrun_d = 1'b1;
                out_count_d = out_count_q + 32'd1;
                idle_d      = '0;
            end else if (idle_q < TIMEOUT) begin
                idle_d = idle_q + 32'd1;
            end
            if (idle_d == TIMEOUT) timeout_d = 1'b1;
        end
    end

    // The run ends on the edge that takes the last word or exhausts the idle budget.
    assign run_end = in_run && ((out_count_d == OUT_TOKENS) || (idle_d == TIMEOUT));

    // Sink counter and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count_q <= '0;
            idle_q      <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            out_count_q <= out_count_d;
            idle_q      <= idle_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    // Run sequencer with registered flush/busy/done/pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_FLUSH;
                        fcnt_q  <= '0;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (fcnt_q == (FLUSH_CYCLES - 1)) begin
                        state_q <= S_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q + 32'd1;
                    end
                end
                S_RUN: begin
                    if (run_end) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !timeout_d && !overrun_d && !underrun_d &&
                                   (out_count_d == OUT_TOKENS);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // XOR of all lanes of the presented output word.
    always_comb begin
        lane_xor = '0;
        for (int unsigned l = 0; l < LANES; l++) lane_xor = lane_xor ^ out_data[l];
    end

`ifdef HARNESS_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q;

    // Output signature, folded on every accepted output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else if (begin_run) begin
            chk_q <= '0;
        end else if (in_run && out_write_valid) begin
            chk_q <= DATA_W'(chk_step(LANE_W_MAX'(chk_q), LANE_W_MAX'(lane_xor), DATA_W));
        end
    end

    assign checksum = chk_q;
`else
    logic unused_lane_xor;
    assign unused_lane_xor = ^lane_xor;
    assign checksum        = '0;
`endif

    assign flush     = flush_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_stencil_stream_harness.sv
// Bench for stencil_stream_harness: two instances (single-lane and four-lane
// wrapping ramp), a spec-level reference model compared every cycle, and
// hand-computed literal expectations at key points.
`timescale 1ns/1ps
module tb_stencil_stream_harness;

    localparam int P_IDLE = 0, P_FLUSH = 1, P_RUN = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance 0: LANES=1, ramp 0,1,2..., 8 in / 8 out, flush 2 cycles
    logic        start0 = 1'b0, rd0 = 1'b0, wv0 = 1'b0;
    logic [15:0] od0 [0:0];
    logic [15:0] id0 [0:0];
    logic        flush0, busy0, done0, pass0, to0, ov0, un0;
    logic [31:0] cnt0;
    logic [15:0] chk0;

    // instance 1: LANES=4, STRIDE=2, START=0xFFFA, 4 in / 4 out, flush 1 cycle
    logic        start1 = 1'b0, rd1 = 1'b0, wv1 = 1'b0;
    logic [15:0] od1 [0:3];
    logic [15:0] id1 [0:3];
    logic        flush1, busy1, done1, pass1, to1, ov1, un1;
    logic [31:0] cnt1;
    logic [15:0] chk1;

    stencil_stream_harness #(
        .LANES(1), .DATA_W(16), .IN_TOKENS(8), .OUT_TOKENS(8),
        .START_VAL(0), .STRIDE(1), .FLUSH_CYCLES(2), .TIMEOUT(16)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .flush(flush0),
        .in_read_en(rd0), .in_data(id0), .out_write_valid(wv0), .out_data(od0),
        .busy(busy0), .done(done0), .pass(pass0), .timeout(to0),
        .overrun(ov0), .underrun(un0), .out_count(cnt0), .checksum(chk0)
    );

    stencil_stream_harness #(
        .LANES(4), .DATA_W(16), .IN_TOKENS(4), .OUT_TOKENS(4),
        .START_VAL(32'hFFFA), .STRIDE(2), .FLUSH_CYCLES(1), .TIMEOUT(16)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .flush(flush1),
        .in_read_en(rd1), .in_data(id1), .out_write_valid(wv1), .out_data(od1),
        .busy(busy1), .done(done1), .pass(pass1), .timeout(to1),
        .overrun(ov1), .underrun(un1), .out_count(cnt1), .checksum(chk1)
    );

    function automatic int c_lanes(input int d);  return (d == 0) ? 1 : 4;        endfunction
    function automatic int c_in(input int d);     return (d == 0) ? 8 : 4;        endfunction
    function automatic int c_out(input int d);    return (d == 0) ? 8 : 4;        endfunction
    function automatic int c_start(input int d);  return (d == 0) ? 0 : 'hFFFA;   endfunction
    function automatic int c_stride(input int d); return (d == 0) ? 1 : 2;        endfunction
    function automatic int c_fc(input int d);     return (d == 0) ? 2 : 1;        endfunction
    localparam int C_TMO = 16;

    // reference model state, one slot per instance
    int          m_phase [2] = '{0, 0};
    int          m_fleft [2] = '{0, 0};
    int          m_words [2] = '{0, 0};
    int          m_outs  [2] = '{0, 0};
    int          m_idle  [2] = '{0, 0};
    logic [15:0] m_chk   [2] = '{16'h0, 16'h0};
    logic        m_to    [2] = '{1'b0, 1'b0};
    logic        m_ov    [2] = '{1'b0, 1'b0};
    logic        m_un    [2] = '{1'b0, 1'b0};
    logic        m_pass  [2] = '{1'b0, 1'b0};

    task automatic m_clear(input int d);
        m_words[d] = 0; m_outs[d] = 0; m_idle[d] = 0; m_chk[d] = 16'h0;
        m_to[d] = 1'b0; m_ov[d] = 1'b0; m_un[d] = 1'b0; m_pass[d] = 1'b0;
    endtask

    task automatic m_step(input int d, input logic st, input logic rd,
                          input logic wv, input logic [15:0] x);
        case (m_phase[d])
            P_IDLE, P_DONE: if (st) begin
                m_phase[d] = P_FLUSH;
                m_fleft[d] = c_fc(d);
                m_clear(d);
            end
            P_FLUSH: begin
                m_fleft[d] = m_fleft[d] - 1;
                if (m_fleft[d] == 0) m_phase[d] = P_RUN;
            end
            default: begin
                if (rd) begin
                    if (m_words[d] < c_in(d)) m_words[d] = m_words[d] + 1;
                    else m_ov[d] = 1'b1;
                end
                if (wv) begin
                    if (m_outs[d] >= c_out(d)) m_un[d] = 1'b1;
                    m_outs[d] = m_outs[d] + 1;
                    m_idle[d] = 0;
                    m_chk[d]  = {m_chk[d][14:0], m_chk[d][15]} ^ x;
                end else if (m_idle[d] < C_TMO) begin
                    m_idle[d] = m_idle[d] + 1;
                end
                if (m_outs[d] == c_out(d) || m_idle[d] == C_TMO) begin
                    m_to[d]    = (m_idle[d] == C_TMO);
                    m_phase[d] = P_DONE;
                    m_pass[d]  = !m_to[d] && !m_ov[d] && !m_un[d] && (m_outs[d] == c_out(d));
                end
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] = P_IDLE;
                m_fleft[d] = 0;
                m_clear(d);
            end
        end else begin
            m_step(0, start0, rd0, wv0, od0[0]);
            m_step(1, start1, rd1, wv1, od1[0] ^ od1[1] ^ od1[2] ^ od1[3]);
        end
    end

    function automatic logic [63:0] exp_lane(input int d, input int l);
        int k;
        int v;
        k = (m_words[d] < c_in(d)) ? m_words[d] : c_in(d) - 1;
        v = c_start(d) + (k * c_lanes(d) + l) * c_stride(d);
        return 64'(v & 'hFFFF);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int d, input logic fl, input logic bs, input logic dn,
                       input logic ps, input logic tmo, input logic ovr, input logic unr,
                       input logic [31:0] cnt, input logic [15:0] cs, input logic [63:0] lanes);
        logic [15:0] exp_cs;
`ifdef HARNESS_CHECKSUM_EN
        exp_cs = m_chk[d];
`else
        exp_cs = 16'h0;
`endif
        check($sformatf("d%0d.flush", d),    64'(fl),  64'(m_phase[d] == P_FLUSH));
        check($sformatf("d%0d.busy", d),     64'(bs),  64'(m_phase[d] == P_FLUSH || m_phase[d] == P_RUN));
        check($sformatf("d%0d.done", d),     64'(dn),  64'(m_phase[d] == P_DONE));
        check($sformatf("d%0d.timeout", d),  64'(tmo), 64'(m_to[d]));
        check($sformatf("d%0d.overrun", d),  64'(ovr), 64'(m_ov[d]));
        check($sformatf("d%0d.underrun", d), 64'(unr), 64'(m_un[d]));
        check($sformatf("d%0d.out_count", d), 64'(cnt), 64'(m_outs[d]));
        check($sformatf("d%0d.checksum", d), 64'(cs),  64'(exp_cs));
        if (m_phase[d] == P_DONE) check($sformatf("d%0d.pass", d), 64'(ps), 64'(m_pass[d]));
        for (int l = 0; l < c_lanes(d); l++)
            check($sformatf("d%0d.in_data[%0d]", d, l), 64'(lanes[16*l +: 16]), exp_lane(d, l));
    endtask

    always @(negedge clk) begin
        cmp(0, flush0, busy0, done0, pass0, to0, ov0, un0, cnt0, chk0, {48'h0, id0[0]});
        cmp(1, flush1, busy1, done1, pass1, to1, ov1, un1, cnt1, chk1,
            {id1[3], id1[2], id1[1], id1[0]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        od0[0] = 16'h0;
        for (int l = 0; l < 4; l++) od1[l] = 16'(l + 1);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst.in_data0", 64'(id0[0]), 64'h0);
        check("rst.in_data1", 64'({id1[0], id1[1], id1[2], id1[3]}), 64'hFFFA_FFFC_FFFE_0000);
        check("rst.flush0", 64'(flush0), 64'h0);
        check("rst.done0", 64'(done0), 64'h0);
        check("rst.count0", 64'(cnt0), 64'h0);

        // single-lane echo run, read and write together every cycle
        start0 = 1'b1; tick(); start0 = 1'b0;
        check("s1.flush_rise", 64'(flush0), 64'h1);
        tick();
        check("s1.flush_left", 64'(flush0), 64'h1);
        tick();
        check("s1.run_busy", 64'(busy0), 64'h1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("s1.ramp%0d", k), 64'(id0[0]), 64'(k));
            rd0 = 1'b1; wv0 = 1'b1; od0[0] = 16'(k);
            tick();
        end
        rd0 = 1'b0; wv0 = 1'b0;
        check("s1.done", 64'(done0), 64'h1);
        check("s1.count", 64'(cnt0), 64'd8);
        check("s1.pass", 64'(pass0), 64'h1);
        check("s1.in_frozen", 64'(id0[0]), 64'd7);

        // restart from DONE; three words then stall into the timeout
        start0 = 1'b1; tick(); start0 = 1'b0; tick(); tick();
        wv0 = 1'b1; od0[0] = 16'h0003; tick();
`ifdef HARNESS_CHECKSUM_EN
        check("s2.chk_a", 64'(chk0), 64'h0003);
`else
        check("s2.chk_a", 64'(chk0), 64'h0);
`endif
        od0[0] = 16'h0005; tick();
`ifdef HARNESS_CHECKSUM_EN
        check("s2.chk_b", 64'(chk0), 64'h0003);
`else
        check("s2.chk_b", 64'(chk0), 64'h0);
`endif
        od0[0] = 16'h0007; tick();
        wv0 = 1'b0;
        n = 0;
        while (!done0 && n < 40) begin
            tick();
            n++;
        end
        check("s2.timeout_latency", 64'(n), 64'd16);
        check("s2.timeout", 64'(to0), 64'h1);
        check("s2.pass", 64'(pass0), 64'h0);
        check("s2.count", 64'(cnt0), 64'd3);
`ifdef HARNESS_CHECKSUM_EN
        check("s2.chk_c", 64'(chk0), 64'h0001);
`endif

        // four-lane wrapping ramp, reads beyond the supply
        start1 = 1'b1; tick(); start1 = 1'b0; tick();
        check("s4.word0", 64'({id1[0], id1[1], id1[2], id1[3]}), 64'hFFFA_FFFC_FFFE_0000);
        rd1 = 1'b1; tick();
        check("s4.word1", 64'({id1[0], id1[1], id1[2], id1[3]}), 64'h0002_0004_0006_0008);
        for (int k = 0; k < 5; k++) tick();
        rd1 = 1'b0;
        check("s4.overrun", 64'(ov1), 64'h1);
        check("s4.frozen", 64'({id1[0], id1[1], id1[2], id1[3]}), 64'h0012_0014_0016_0018);
        wv1 = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        wv1 = 1'b0;
        check("s4.done", 64'(done1), 64'h1);
        check("s4.pass", 64'(pass1), 64'h0);
        check("s4.count", 64'(cnt1), 64'd4);

        // reset in the middle of a run, then a fresh run
        start0 = 1'b1; tick(); start0 = 1'b0; tick(); tick();
        rd0 = 1'b1; tick(); tick(); rd0 = 1'b0;
        check("s3.ramp_mid", 64'(id0[0]), 64'd2);
        wv0 = 1'b1; od0[0] = 16'h0009; tick(); wv0 = 1'b0;
        rst = 1'b1;
        #1;
        check("s3.rst_in_data", 64'(id0[0]), 64'h0);
        check("s3.rst_busy", 64'(busy0), 64'h0);
        check("s3.rst_count", 64'(cnt0), 64'h0);
        check("s3.rst_chk", 64'(chk0), 64'h0);
        check("s3.rst_flags", 64'({flush0, done0, pass0, to0, ov0, un0}), 64'h0);
        tick();
        rst = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        n = 0;
        while (flush0 && n < 10) begin
            n++;
            tick();
        end
        check("s3.flush_len", 64'(n), 64'd2);
        check("s3.ramp_restart", 64'(id0[0]), 64'h0);
        check("s3.busy", 64'(busy0), 64'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stencil_stream_harness.md
# stencil_stream_harness

Synthesizable, parametrised stimulus/response harness for the stream ports of a generated stencil accelerator, such as the Gaussian pipeline. It sequences the flush pulse, feeds a deterministic ramp on the input stream's read-enable handshake and counts, checksums and timeout-guards the output stream's write-valid traffic. It extends the simulation-only incrementing-source bench to multi-lane streams, configurable ramps, run sequencing and on-chip pass/fail reporting for FPGA bring-up and power-flow runs.

## Interface
- LANES, 1: stencil lanes per stream word
- DATA_W, 16: bits per lane
- IN_TOKENS, 4096: input words to supply before the input stream is exhausted
- OUT_TOKENS, 4096: output words expected
- START_VAL, 0: value of lane 0 of the first input word
- STRIDE, 1: increment between consecutive lanes and words
- FLUSH_CYCLES, 1: flush pulse length in cycles, minimum 1
- TIMEOUT, 65535: maximum idle cycles between output words in RUN
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE
- flush  out  1  flush to the DUT
- in_read_en  in  1  DUT consumes the current input word
- in_data  out  LANES x DATA_W  current input word, unpacked array [0:LANES-1]
- out_write_valid  in  1  DUT presents an output word
- out_data  in  LANES x DATA_W  output word
- busy  out  1  high in FLUSH or RUN
- done  out  1  high in DONE
- pass  out  1  valid when done: no timeout, no overrun, no underrun, counts exact
- timeout  out  1  sticky; idle limit exceeded
- overrun  out  1  sticky; in_read_en seen after IN_TOKENS words were consumed
- underrun  out  1  sticky; out_write_valid seen after OUT_TOKENS words were received
- out_count  out  32  output words received
- checksum  out  DATA_W  running output signature

## Operation
- States: IDLE, FLUSH, RUN, DONE.
- IDLE -> FLUSH on start. On entry, clear counters, clear sticky flags, clear checksum, and load the ramp base with START_VAL.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles, then go to RUN.
  - Handshakes in FLUSH are ignored.
- RUN -> DONE when out_count reaches OUT_TOKENS or the idle counter reaches TIMEOUT.
- DONE -> FLUSH on start. This begins a new run and re-clears everything.
- Input lane l = base + l*STRIDE, taken modulo 2^DATA_W.
- Each sampled in_read_en in RUN advances the base by LANES*STRIDE, also wrapping.
- After IN_TOKENS words have been consumed:
  - in_data holds its last value.
  - Any further in_read_en sets overrun and does not advance the base.
- Each sampled out_write_valid in RUN:
  - increments out_count;
  - resets the idle counter;
  - updates the checksum: new = rotl1(old) XOR (XOR of all lanes).
- An output word beyond OUT_TOKENS sets underrun. It is counted, but it cannot occur unless RUN persists past the count limit.
- Simultaneous in_read_en and out_write_valid are both processed in the same cycle.
- start during FLUSH or RUN is ignored.

## Timing
- Reset values:
  - state IDLE;
  - flush, busy, done, pass, timeout, overrun and underrun all 0;
  - out_count 0, checksum 0;
  - in_data = ramp from START_VAL.
- Reset mid-run aborts immediately to these values.
- in_data is registered. After in_read_en is sampled high at edge n, the next word is visible after edge n and stays stable until the next sampled read_en.
- flush rises on the edge after start is sampled.
- RUN is entered FLUSH_CYCLES edges later.
- done asserts on the edge that samples the final output word. out_count and checksum already include that word.
- The idle counter saturates at TIMEOUT. timeout is set on the same edge as the transition to DONE.

## Configuration
- HARNESS_CHECKSUM_EN:
  - Defined: the checksum register and logic are present.
  - Undefined: checksum is tied to 0 and pass ignores it.
- pass never compares the checksum on chip; comparison is left to the bench or host.

## Structure
- Package stencil_harness_pkg holds:
  - the state enum;
  - the lane-word typedef, parameterised through DATA_W at use;
  - the checksum step function.
- One sub-module, stencil_ramp_source, holds the ramp base register, wrap arithmetic and token count.
- The top module holds the FSM, sink, counters and flags.

## Test plan
- LANES=1, START_VAL=0, STRIDE=1, IN/OUT_TOKENS=8; read_en every cycle, DUT echoes input -> in_data steps 0..7; done with out_count=8, pass=1.
- LANES=4, STRIDE=2, START_VAL=0xFFFA, DATA_W=16 -> first word {FFFA,FFFC,FFFE,0000}, second word {0002,0004,0006,0008}.
- TIMEOUT=16, output stalls after 3 words -> timeout=1, done 16 cycles after the third word, pass=0, out_count=3.
- in_read_en held high beyond IN_TOKENS=4 -> overrun=1, in_data frozen at the fourth word.
- rst asserted mid-RUN, then start -> all outputs return to reset values; flush pulses FLUSH_CYCLES; the ramp restarts at START_VAL.
- Two outputs {0x0003} then {0x0005}, with HARNESS_CHECKSUM_EN defined -> checksum 0x0003 then 0x0003; without the macro -> checksum stays 0.
